vga_line_sched: RTL
===================

VGA_LINE_SCHED -- requirements
Module: vga_line_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter ADDR_W, default 19, meaning the frame-buffer word address width.
Ports (name, direction, width, meaning):
REQ-004 clk  in  1  pixel clock; single clock domain.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 hcount  in  10  active-area pixel x from the VGA timing block.
REQ-007 vcount  in  10  active-area line y from the VGA timing block.
REQ-008 vga_blk  in  1  high inside the active area.
REQ-009 vga_vs  in  1  vertical sync, low during sync.
REQ-010 data_out  out  24  pixel RGB to the timing block data_in.
REQ-011 mem_addr  out  ADDR_W  single-port SRAM word address.
REQ-012 mem_rd  out  1  read strobe; mem_rdata is valid exactly 1 cycle later.
REQ-013 mem_wr  out  1  write strobe.
REQ-014 mem_wdata  out  24  write data.
REQ-015 mem_rdata  in  24  read data.
REQ-016 wr_req  in  1  pixel-writer request; held until acknowledged.
REQ-017 wr_addr  in  ADDR_W  pixel-writer address.
REQ-018 wr_data  in  24  pixel-writer data.
REQ-019 wr_ack  out  1  one-cycle pulse; the write is issued in that same cycle.
REQ-020 underrun_err  out  1  sticky fetch-overrun flag.

Function
REQ-021 The block SHALL hold two internal line buffers, B0 and B1, each H_ACTIVE x 24 bits; line y is stored in buffer B[y[0]].
REQ-022 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
- IDLE -> FETCH on a trigger.
- FETCH -> DRAIN after the read with x = H_ACTIVE-1 is issued.
- DRAIN -> IDLE after 1 cycle.
REQ-023 Trigger A SHALL be the falling edge of vga_vs (one-cycle registered compare), and SHALL fetch line 0.
REQ-024 Trigger B SHALL be the rising edge of vga_blk with vcount = y < V_ACTIVE-1, and SHALL fetch line y+1; no trigger SHALL fire on line V_ACTIVE-1.
REQ-025 In FETCH, the block SHALL assert mem_rd on every cycle with x = 0..H_ACTIVE-1 and mem_addr = fetch_y*H_ACTIVE + x.
- For H_ACTIVE = 640, fetch_y*640 SHALL be computed as (y<<9)+(y<<7), truncated to ADDR_W.
REQ-026 mem_rdata SHALL be written into B[fetch_y[0]] at x delayed by 1 cycle; the last word SHALL be captured in DRAIN.
REQ-027 data_out SHALL equal B[vcount[0]][hcount] registered, giving 1-cycle latency, when vga_blk=1, and SHALL be 0 otherwise.
REQ-028 The block SHALL use fixed-priority arbitration with fetch highest.
- The writer SHALL be granted only in IDLE or DRAIN.
- On grant: mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data and wr_ack=1, all in the same cycle.
- Consecutive grants SHALL be allowed back-to-back.
REQ-029 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-030 When neither a fetch nor a grant is active, the block SHALL drive mem_rd=0, mem_wr=0 and hold mem_addr.
REQ-031 If a trigger occurs in FETCH or DRAIN, the block SHALL:
- set underrun_err=1 (sticky until reset),
- abort the current fetch,
- restart FETCH at x=0 for the new line on the next cycle.
REQ-032 If a trigger and a pending wr_req occur in the same cycle in IDLE, fetch SHALL win and wr_ack SHALL stay 0.
REQ-033 The x counter SHALL be $clog2(H_ACTIVE) bits wide and SHALL never exceed H_ACTIVE-1.

Reset
REQ-034 On rst=0, asynchronously:
- state=IDLE,
- x=0,
- data_out=0, mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0, wr_ack=0, underrun_err=0,
- edge-detect registers loaded so that no trigger is produced on reset release.
REQ-035 Line-buffer contents SHALL NOT be reset; they are undefined until first fetched.
REQ-036 Reset asserted mid-FETCH SHALL abandon the fetch with no further mem_rd.

Verification
REQ-037 vga_vs falls -> next cycle FETCH; mem_rd=1 for 640 consecutive cycles with mem_addr 0..639; B0 is filled.
REQ-038 vga_blk rises with vcount=5 -> mem_addr runs 3840..4479; data lands in B0; display of line 5 reads B1, unaffected.
REQ-039 wr_req held during FETCH -> wr_ack=0 throughout; wr_ack=1 in DRAIN with mem_wr=1 and mem_addr=wr_addr.
REQ-040 Second trigger injected at x=300 -> underrun_err=1; next mem_addr = new_y*640; the flag persists until reset.
REQ-041 vcount=479 with vga_blk rising -> no FETCH; writer requests are acknowledged on every cycle.
REQ-042 Reset pulsed at x=100 of FETCH -> all outputs 0 immediately; no mem_rd until the next trigger after release.

Source files
------------

// File: rtl/vga_line_sched.sv
// Double-buffered VGA line scheduler: fetches the next display line from a single-port SRAM
// into one of two line buffers while the other is scanned out, and arbitrates a pixel writer.
module vga_line_sched #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              vga_blk,
  input  logic              vga_vs,
  output logic [23:0]       data_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic              wr_ack,
  output logic              underrun_err
);

  localparam int unsigned   XW       = $clog2(H_ACTIVE);
  localparam logic [XW-1:0] XLast    = XW'(H_ACTIVE - 1);
  localparam logic [9:0]    LastLine = 10'(V_ACTIVE - 1);
  localparam logic [9:0]    HLimit   = 10'(H_ACTIVE);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [9:0]        fy_q, fy_d;
  logic              err_q, err_d;
  logic              vs_q, blk_q, run_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       wdata_q;
  logic [23:0]       dout_q;

  logic              trig_a, trig_b, trig;
  logic [9:0]        trig_y;
  logic              grant;
  logic [ADDR_W-1:0] line_base;

  logic              cap_vld_q, cap_sel_q;
  logic [XW-1:0]     cap_x_q;
  logic [23:0]       lb0 [H_ACTIVE];
  logic [23:0]       lb1 [H_ACTIVE];
  logic [23:0]       pix;

  // Edge detectors compare against last cycle's sample.
  assign trig_a = vs_q & ~vga_vs;
  assign trig_b = ~blk_q & vga_blk & (vcount < LastLine);
  assign trig   = trig_a | trig_b;
  assign trig_y = trig_a ? 10'd0 : vcount + 10'd1;

  always_comb begin
    if (H_ACTIVE == 640) begin
      line_base = (ADDR_W'(fy_q) << 9) + (ADDR_W'(fy_q) << 7);
    end else begin
      line_base = ADDR_W'(fy_q) * ADDR_W'(H_ACTIVE);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    fy_d    = fy_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StFetch;
          x_d     = '0;
          fy_d    = trig_y;
        end
      end
      StFetch: begin
        if (trig) begin
          err_d = 1'b1;
          x_d   = '0;
          fy_d  = trig_y;
        end else if (x_q == XLast) begin
          state_d = StDrain;
          x_d     = '0;
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      StDrain: begin
        if (trig) begin
          err_d   = 1'b1;
          state_d = StFetch;
          x_d     = '0;
          fy_d    = trig_y;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Fetch always wins; run_q keeps the writer off the bus while reset is held.
  always_comb begin
    mem_rd    = (state_q == StFetch);
    grant     = run_q & wr_req & ~trig & (state_q != StFetch);
    mem_wr    = grant;
    wr_ack    = grant;
    mem_addr  = addr_q;
    mem_wdata = grant ? wr_data : wdata_q;
    if (mem_rd) begin
      mem_addr = line_base + ADDR_W'(x_q);
    end else if (grant) begin
      mem_addr = wr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      fy_q      <= '0;
      err_q     <= 1'b0;
      vs_q      <= 1'b0;
      blk_q     <= 1'b1;
      run_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_sel_q <= 1'b0;
      cap_x_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      fy_q      <= fy_d;
      err_q     <= err_d;
      vs_q      <= vga_vs;
      blk_q     <= vga_blk;
      run_q     <= 1'b1;
      addr_q    <= mem_addr;
      wdata_q   <= mem_wdata;
      dout_q    <= pix;
      cap_vld_q <= mem_rd;
      cap_sel_q <= fy_q[0];
      cap_x_q   <= x_q;
    end
  end

  // Line buffers are plain storage with no reset.
  always_ff @(posedge clk) begin
    if (cap_vld_q) begin
      if (cap_sel_q) begin
        lb1[cap_x_q] <= mem_rdata;
      end else begin
        lb0[cap_x_q] <= mem_rdata;
      end
    end
  end

  always_comb begin
    pix = '0;
    if (vga_blk && (hcount < HLimit)) begin
      pix = vcount[0] ? lb1[hcount[XW-1:0]] : lb0[hcount[XW-1:0]];
    end
  end

  assign data_out     = dout_q;
  assign underrun_err = err_q;

endmodule
